// File: rtl/rab_lookup_if.sv
// Request/response bundle between the AXI address channels, the lookup
// controller and the consumer of the translation result.
interface rab_lookup_if #(
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ADDR_WIDTH_PHYS = 40
) ();
  logic                       ar_valid;
  logic                       ar_ready;
  logic [ADDR_WIDTH_VIRT-1:0] ar_addr;
  logic [7:0]                 ar_len;
  logic [2:0]                 ar_size;

  logic                       aw_valid;
  logic                       aw_ready;
  logic [ADDR_WIDTH_VIRT-1:0] aw_addr;
  logic [7:0]                 aw_len;
  logic [2:0]                 aw_size;

  logic                       resp_valid;
  logic                       resp_ready;
  logic                       resp_is_write;
  logic [ADDR_WIDTH_PHYS-1:0] resp_addr;
  logic                       resp_master_select;
  logic                       resp_miss;
  logic                       resp_prot;
  logic                       resp_multi;
  logic                       resp_range_err;

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size,
    output ar_ready,
    input  aw_valid, aw_addr, aw_len, aw_size,
    output aw_ready,
    output resp_valid, resp_is_write, resp_addr, resp_master_select,
    output resp_miss, resp_prot, resp_multi, resp_range_err,
    input  resp_ready
  );

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size,
    input  ar_ready,
    output aw_valid, aw_addr, aw_len, aw_size,
    input  aw_ready,
    input  resp_valid, resp_is_write, resp_addr, resp_master_select,
    input  resp_miss, resp_prot, resp_multi, resp_range_err,
    output resp_ready
  );
endinterface

// File: rtl/rab_lookup_ctrl.sv
// Round-robin sequencer of the shared RAB slice lookup for the AR and AW
// channels, with a registered response handshake and config-update gating.
module rab_lookup_ctrl #(
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int N_SLICES        = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       axi4_aclk,
  input  logic                       axi4_arstn,
  rab_lookup_if.slave                bus,
  output logic                       lk_rw,
  output logic [ADDR_WIDTH_VIRT-1:0] lk_addr_min,
  output logic [ADDR_WIDTH_VIRT-1:0] lk_addr_max,
  input  logic [N_SLICES-1:0]        lk_hit,
  input  logic [N_SLICES-1:0]        lk_prot,
  input  logic                       lk_multiple_hit,
  input  logic                       lk_master_select,
  input  logic [ADDR_WIDTH_PHYS-1:0] lk_out_addr,
  input  logic                       cfg_upd_req,
  output logic                       cfg_upd_ack,
  output logic [CNT_WIDTH-1:0]       miss_cnt,
  input  logic                       miss_cnt_clr
);

  localparam int SUM_W = ADDR_WIDTH_VIRT + 12;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP, S_CFG} state_e;

  state_e                     state_q, state_d;
  logic                       rr_aw_q, rr_aw_d;
  logic                       rw_q, rw_d;
  logic [ADDR_WIDTH_VIRT-1:0] addr_min_q, addr_min_d;
  logic [ADDR_WIDTH_VIRT-1:0] addr_max_q, addr_max_d;
  logic                       range_err_q, range_err_d;
  logic                       resp_is_write_q, resp_is_write_d;
  logic [ADDR_WIDTH_PHYS-1:0] resp_addr_q, resp_addr_d;
  logic                       resp_ms_q, resp_ms_d;
  logic                       resp_miss_q, resp_miss_d;
  logic                       resp_prot_q, resp_prot_d;
  logic                       resp_multi_q, resp_multi_d;
  logic                       resp_range_err_q, resp_range_err_d;
  logic [CNT_WIDTH-1:0]       miss_cnt_q, miss_cnt_d;

  logic                       grant_ar, grant_aw;
  logic [ADDR_WIDTH_VIRT-1:0] sel_addr;
  logic [7:0]                 sel_len;
  logic [2:0]                 sel_size;
  logic [SUM_W-1:0]           span, last;
  logic                       lookup_miss, lookup_prot, lookup_kill;

  assign lookup_miss = ~|lk_hit;
  assign lookup_prot = |lk_prot;
  assign lookup_kill = lookup_miss | lookup_prot | lk_multiple_hit | range_err_q;

  // rr_aw_q set means AW wins when both channels request together
  always_comb begin
    grant_ar = 1'b0;
    grant_aw = 1'b0;
    if (state_q == S_IDLE && !cfg_upd_req) begin
      if (bus.ar_valid && (!bus.aw_valid || !rr_aw_q)) grant_ar = 1'b1;
      else if (bus.aw_valid)                            grant_aw = 1'b1;
    end
  end

  // Widened sum so a burst running past the top of the address space is visible
  always_comb begin
    sel_addr = grant_aw ? bus.aw_addr : bus.ar_addr;
    sel_len  = grant_aw ? bus.aw_len  : bus.ar_len;
    sel_size = grant_aw ? bus.aw_size : bus.ar_size;
    span     = (SUM_W'(sel_len) + SUM_W'(1)) << sel_size;
    last     = SUM_W'(sel_addr) + span - SUM_W'(1);
  end

  always_comb begin
    state_d          = state_q;
    rr_aw_d          = rr_aw_q;
    rw_d             = rw_q;
    addr_min_d       = addr_min_q;
    addr_max_d       = addr_max_q;
    range_err_d      = range_err_q;
    resp_is_write_d  = resp_is_write_q;
    resp_addr_d      = resp_addr_q;
    resp_ms_d        = resp_ms_q;
    resp_miss_d      = resp_miss_q;
    resp_prot_d      = resp_prot_q;
    resp_multi_d     = resp_multi_q;
    resp_range_err_d = resp_range_err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_upd_req) begin
          state_d = S_CFG;
        end else if (grant_ar || grant_aw) begin
          rr_aw_d     = grant_ar;
          rw_d        = grant_aw;
          addr_min_d  = sel_addr;
          addr_max_d  = last[ADDR_WIDTH_VIRT-1:0];
          range_err_d = |last[SUM_W-1:ADDR_WIDTH_VIRT];
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        resp_is_write_d  = rw_q;
        resp_miss_d      = lookup_miss;
        resp_prot_d      = lookup_prot;
        resp_multi_d     = lk_multiple_hit;
        resp_range_err_d = range_err_q;
        resp_addr_d      = lookup_kill ? '0 : lk_out_addr;
        resp_ms_d        = ~lookup_kill & lk_master_select;
        state_d          = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = cfg_upd_req ? S_CFG : S_IDLE;
      end
      S_CFG: begin
        if (!cfg_upd_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (miss_cnt_clr)
      miss_cnt_d = '0;
    else if (state_q == S_LOOKUP && lookup_miss && !(&miss_cnt_q))
      miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_q          <= S_IDLE;
      rr_aw_q          <= 1'b0;
      resp_is_write_q  <= 1'b0;
      resp_addr_q      <= '0;
      resp_ms_q        <= 1'b0;
      resp_miss_q      <= 1'b0;
      resp_prot_q      <= 1'b0;
      resp_multi_q     <= 1'b0;
      resp_range_err_q <= 1'b0;
      miss_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      rr_aw_q          <= rr_aw_d;
      resp_is_write_q  <= resp_is_write_d;
      resp_addr_q      <= resp_addr_d;
      resp_ms_q        <= resp_ms_d;
      resp_miss_q      <= resp_miss_d;
      resp_prot_q      <= resp_prot_d;
      resp_multi_q     <= resp_multi_d;
      resp_range_err_q <= resp_range_err_d;
      miss_cnt_q       <= miss_cnt_d;
    end
  end

  // Request capture is only consumed in LOOKUP, after a grant has loaded it
  always_ff @(posedge axi4_aclk) begin
    rw_q        <= rw_d;
    addr_min_q  <= addr_min_d;
    addr_max_q  <= addr_max_d;
    range_err_q <= range_err_d;
  end

  assign bus.ar_ready           = grant_ar & axi4_arstn;
  assign bus.aw_ready           = grant_aw & axi4_arstn;
  assign lk_rw                  = (state_q == S_LOOKUP) & rw_q;
  assign lk_addr_min            = (state_q == S_LOOKUP) ? addr_min_q : '0;
  assign lk_addr_max            = (state_q == S_LOOKUP) ? addr_max_q : '0;
  assign bus.resp_valid         = (state_q == S_RESP);
  assign bus.resp_is_write      = resp_is_write_q;
  assign bus.resp_addr          = resp_addr_q;
  assign bus.resp_master_select = resp_ms_q;
  assign bus.resp_miss          = resp_miss_q;
  assign bus.resp_prot          = resp_prot_q;
  assign bus.resp_multi         = resp_multi_q;
  assign bus.resp_range_err     = resp_range_err_q;
  assign cfg_upd_ack            = (state_q == S_CFG);
  assign miss_cnt               = miss_cnt_q;

endmodule

// File: tb/tb_rab_lookup_ctrl.sv
// Scoreboard bench for rab_lookup_ctrl: expected responses are queued at the
// request handshake and compared when the response handshake happens.
module tb_rab_lookup_ctrl;
  localparam int AV = 32;
  localparam int AP = 40;
  localparam int NS = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rab_lookup_if #(.ADDR_WIDTH_VIRT(AV), .ADDR_WIDTH_PHYS(AP)) bus ();

  logic          lk_rw;
  logic [AV-1:0] lk_addr_min, lk_addr_max;
  logic [NS-1:0] lk_hit, lk_prot;
  logic          lk_mh, lk_ms;
  logic [AP-1:0] lk_oa;
  logic          cfg_upd_req, cfg_upd_ack, miss_cnt_clr;
  logic [CW-1:0] miss_cnt;

  rab_lookup_ctrl #(
    .ADDR_WIDTH_VIRT(AV), .ADDR_WIDTH_PHYS(AP), .N_SLICES(NS), .CNT_WIDTH(CW)
  ) dut (
    .axi4_aclk        (clk),
    .axi4_arstn       (rst_n),
    .bus              (bus),
    .lk_rw            (lk_rw),
    .lk_addr_min      (lk_addr_min),
    .lk_addr_max      (lk_addr_max),
    .lk_hit           (lk_hit),
    .lk_prot          (lk_prot),
    .lk_multiple_hit  (lk_mh),
    .lk_master_select (lk_ms),
    .lk_out_addr      (lk_oa),
    .cfg_upd_req      (cfg_upd_req),
    .cfg_upd_ack      (cfg_upd_ack),
    .miss_cnt         (miss_cnt),
    .miss_cnt_clr     (miss_cnt_clr)
  );

  typedef struct {
    logic          w;
    logic [AV-1:0] amin;
    logic [AV-1:0] amax;
    logic [AP-1:0] addr;
    logic          ms, miss, prot, multi, rerr;
    int            hs;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_miss = '0;
  logic          rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: byte span from len/size, wrap flag from a 64-bit sum
  function automatic exp_t model(input logic w, input logic [AV-1:0] a,
                                 input logic [7:0] len, input logic [2:0] sz);
    exp_t e;
    logic [63:0] nb, lst;
    logic kill;
    nb     = (64'(len) + 64'd1) << sz;
    lst    = 64'(a) + nb - 64'd1;
    e.w    = w;
    e.amin = a;
    e.amax = lst[AV-1:0];
    e.rerr = ((lst >> AV) != 64'd0);
    e.miss = (lk_hit == '0);
    e.prot = (lk_prot != '0);
    e.multi = lk_mh;
    kill   = e.miss | e.prot | e.multi | e.rerr;
    e.addr = kill ? '0 : lk_oa;
    e.ms   = kill ? 1'b0 : lk_ms;
    e.hs   = cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid && !rv_prev) begin
        if (sbq.size() > 0) chk("resp_latency", 64'(cyc - sbq[0].hs), 64'd2);
        else                chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
      end
      if (bus.resp_valid && bus.resp_ready && sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("resp_is_write", 64'(bus.resp_is_write), 64'(mon_e.w));
        chk("resp_addr", 64'(bus.resp_addr), 64'(mon_e.addr));
        chk("resp_master_select", 64'(bus.resp_master_select), 64'(mon_e.ms));
        chk("resp_miss", 64'(bus.resp_miss), 64'(mon_e.miss));
        chk("resp_prot", 64'(bus.resp_prot), 64'(mon_e.prot));
        chk("resp_multi", 64'(bus.resp_multi), 64'(mon_e.multi));
        chk("resp_range_err", 64'(bus.resp_range_err), 64'(mon_e.rerr));
      end
    end
    rv_prev = rst_n ? bus.resp_valid : 1'b0;
  end

  // Call from posedge+#1; returns at the negedge of the RESP cycle
  task automatic take_grant(input bit clr_lk, output bit w, output int hs);
    exp_t e;
    bit found;
    found = 1'b0;
    w  = 1'b0;
    hs = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ar_ready || bus.aw_ready) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      chk("grant_timeout", 64'd0, 64'd1);
      return;
    end
    chk("single_grant", 64'(bus.ar_ready & bus.aw_ready), 64'd0);
    chk("lk_zero_in_idle", 64'(lk_addr_max), 64'd0);
    w  = bus.aw_ready;
    hs = cyc;
    if (w) e = model(1'b1, bus.aw_addr, bus.aw_len, bus.aw_size);
    else   e = model(1'b0, bus.ar_addr, bus.ar_len, bus.ar_size);
    sbq.push_back(e);
    @(posedge clk); #1;
    if (w) bus.aw_valid = 1'b0;
    else   bus.ar_valid = 1'b0;
    miss_cnt_clr = clr_lk;
    @(negedge clk);
    chk("lk_rw", 64'(lk_rw), 64'(e.w));
    chk("lk_addr_min", 64'(lk_addr_min), 64'(e.amin));
    chk("lk_addr_max", 64'(lk_addr_max), 64'(e.amax));
    chk("lookup_no_resp", 64'(bus.resp_valid), 64'd0);
    if (clr_lk)                             exp_miss = '0;
    else if (e.miss && exp_miss != '1)      exp_miss = exp_miss + 16'd1;
    @(posedge clk); #1;
    miss_cnt_clr = 1'b0;
    @(negedge clk);
    chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
  endtask

  task automatic set_lk(input logic [NS-1:0] hit, input logic [NS-1:0] prot,
                        input logic mh, input logic ms, input logic [AP-1:0] oa);
    lk_hit = hit; lk_prot = prot; lk_mh = mh; lk_ms = ms; lk_oa = oa;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    int hs, t0;
    bus.ar_valid = 1'b1; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0;
    bus.aw_valid = 1'b1; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0;
    bus.resp_ready = 1'b1;
    cfg_upd_req = 1'b0; miss_cnt_clr = 1'b0;
    set_lk('0, '0, 1'b0, 1'b0, '0);

    #12;
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_addr", 64'(bus.resp_addr), 64'd0);
    chk("rst_cfg_ack", 64'(cfg_upd_ack), 64'd0);
    chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    chk("rst_lk_max", 64'(lk_addr_max), 64'd0);
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Both channels requesting: expect AR, AW, AR, AW
    bus.ar_addr = 32'h0000_4000; bus.ar_len = 8'd1; bus.ar_size = 3'd3;
    bus.aw_addr = 32'h0000_5000; bus.aw_len = 8'd0; bus.aw_size = 3'd2;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_lk(16'h0004, 16'h0000, 1'b0, 1'b0, 40'h12_3456_7000);
        1: set_lk(16'h0100, 16'h0100, 1'b0, 1'b1, 40'h12_3456_8000);
        2: set_lk(16'h0011, 16'h0000, 1'b1, 1'b1, 40'h12_3456_9000);
        default: set_lk(16'h8000, 16'h0000, 1'b0, 1'b1, 40'hAB_CDEF_0123);
      endcase
      bus.ar_valid = 1'b1; bus.aw_valid = 1'b1;
      take_grant(1'b0, w, hs);
      chk("rr_order", 64'(w), 64'(i % 2));
      @(posedge clk); #1;
    end
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;

    // Single AR hit
    set_lk(16'h0001, 16'h0000, 1'b0, 1'b0, 40'h80_0000_1000);
    bus.ar_addr = 32'h0000_1000; bus.ar_len = 8'd3; bus.ar_size = 3'd2; bus.ar_valid = 1'b1;
    take_grant(1'b0, w, hs);
    chk("ar_only_dir", 64'(w), 64'd0);
    @(posedge clk); #1;

    // Miss increments the counter
    set_lk(16'h0000, 16'h0000, 1'b0, 1'b1, 40'h55_5555_5555);
    bus.ar_addr = 32'h0000_6000; bus.ar_len = 8'd0; bus.ar_size = 3'd0; bus.ar_valid = 1'b1;
    take_grant(1'b0, w, hs);
    @(posedge clk); #1;

    // Preload counter at all-ones, then a miss must not wrap it
    force dut.miss_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.miss_cnt_q;
    exp_miss = 16'hFFFF;
    @(negedge clk);
    chk("miss_preload", 64'(miss_cnt), 64'hFFFF);
    @(posedge clk); #1;
    bus.aw_addr = 32'h0000_7000; bus.aw_len = 8'd2; bus.aw_size = 3'd1; bus.aw_valid = 1'b1;
    take_grant(1'b0, w, hs);
    @(posedge clk); #1;

    // Clear coincident with a miss wins, then the next miss counts from zero
    bus.ar_valid = 1'b1;
    take_grant(1'b1, w, hs);
    @(posedge clk); #1;
    bus.ar_valid = 1'b1;
    take_grant(1'b0, w, hs);
    @(posedge clk); #1;

    // Write burst wrapping past the top of the address space
    set_lk(16'h0004, 16'h0000, 1'b0, 1'b1, 40'h11_2222_3333);
    bus.aw_addr = 32'hFFFF_FFF0; bus.aw_len = 8'd7; bus.aw_size = 3'd2; bus.aw_valid = 1'b1;
    take_grant(1'b0, w, hs);
    chk("range_dir", 64'(w), 64'd1);
    @(posedge clk); #1;

    // Config request arriving while a response is stalled
    set_lk(16'h0002, 16'h0000, 1'b0, 1'b0, 40'h00_0000_2000);
    bus.resp_ready = 1'b0;
    bus.ar_addr = 32'h0000_2000; bus.ar_len = 8'd0; bus.ar_size = 3'd3; bus.ar_valid = 1'b1;
    take_grant(1'b0, w, hs);
    @(posedge clk); #1;
    cfg_upd_req = 1'b1; bus.ar_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("cfg_hold_ar_ready", 64'(bus.ar_ready), 64'd0);
      chk("cfg_hold_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("cfg_hold_ack", 64'(cfg_upd_ack), 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("cfg_hs_ack", 64'(cfg_upd_ack), 64'd0);
    chk("cfg_hs_ar_ready", 64'(bus.ar_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("cfg_ack", 64'(cfg_upd_ack), 64'd1);
      chk("cfg_ar_ready", 64'(bus.ar_ready), 64'd0);
    end
    @(posedge clk); #1;
    cfg_upd_req = 1'b0;
    t0 = cyc;
    @(negedge clk);
    chk("cfg_fall_ack", 64'(cfg_upd_ack), 64'd1);
    chk("cfg_fall_ar_ready", 64'(bus.ar_ready), 64'd0);
    take_grant(1'b0, w, hs);
    chk("cfg_release_delay", 64'(hs - t0), 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a lookup
    set_lk(16'h0001, 16'h0000, 1'b0, 1'b0, 40'h00_0000_3000);
    bus.ar_addr = 32'h0000_3000; bus.ar_len = 8'd0; bus.ar_size = 3'd2; bus.ar_valid = 1'b1;
    @(negedge clk);
    chk("prerst_grant", 64'(bus.ar_ready), 64'd1);
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    chk("prerst_lookup", 64'(lk_addr_min), 64'h3000);
    bus.ar_valid = 1'b1; bus.aw_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ar_ready", 64'(bus.ar_ready), 64'd0);
    chk("midrst_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("midrst_lk_min", 64'(lk_addr_min), 64'd0);
    chk("midrst_lk_max", 64'(lk_addr_max), 64'd0);
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_cfg_ack", 64'(cfg_upd_ack), 64'd0);
    chk("midrst_miss_cnt", 64'(miss_cnt), 64'd0);
    exp_miss = '0;
    @(posedge clk); #1;
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    @(posedge clk); #1;
    bus.ar_valid = 1'b1; bus.aw_valid = 1'b1;
    take_grant(1'b0, w, hs);
    chk("postrst_first_ar", 64'(w), 64'd0);
    @(posedge clk); #1;
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rab_lookup_ctrl.md
Name: rab_lookup_ctrl

Overview:
- Sequences the shared RAB slice-lookup datapath between two requesters: the AXI read-address (AR) and write-address (AW) channels.
- Arbitrates round-robin and computes the transaction address range.
- Drives the slice array, registers its hit/miss/protection result and returns it through a valid/ready response handshake.
- Gates slice reconfiguration: a configuration update only starts when no lookup is in flight.

Parameters:
- ADDR_WIDTH_VIRT, 32, virtual address width.
- ADDR_WIDTH_PHYS, 40, physical address width.
- N_SLICES, 16, number of slices in the lookup array.
- CNT_WIDTH, 16, width of the saturating miss counter.

Ports:
- axi4_aclk  in  1  clock.
- axi4_arstn  in  1  asynchronous active-low reset.
- ar_valid / ar_ready  in / out  1 / 1  read-request handshake.
- ar_addr  in  ADDR_WIDTH_VIRT  read start address.
- ar_len  in  8  read burst length minus 1.
- ar_size  in  3  read beat size, log2 bytes.
- aw_valid / aw_ready / aw_addr / aw_len / aw_size  same as AR, for writes.
- lk_rw  out  1  to slice array: 1 = write.
- lk_addr_min  out  ADDR_WIDTH_VIRT  to slice array.
- lk_addr_max  out  ADDR_WIDTH_VIRT  to slice array.
- lk_hit  in  N_SLICES  from slice array.
- lk_prot  in  N_SLICES  from slice array.
- lk_multiple_hit  in  1  from slice array.
- lk_master_select  in  1  from slice array.
- lk_out_addr  in  ADDR_WIDTH_PHYS  from slice array.
- resp_valid / resp_ready  out / in  1 / 1  response handshake.
- resp_is_write  out  1  direction of the answered request.
- resp_addr  out  ADDR_WIDTH_PHYS  translated address.
- resp_master_select  out  1  selected master port.
- resp_miss  out  1  no slice hit.
- resp_prot  out  1  protection violation.
- resp_multi  out  1  multiple slices hit.
- resp_range_err  out  1  address range wrapped.
- cfg_upd_req  in  1  configuration update requested.
- cfg_upd_ack  out  1  lookup quiescent, config may be written.
- miss_cnt  out  CNT_WIDTH  saturating miss count.
- miss_cnt_clr  in  1  synchronous clear of miss_cnt.

Behaviour:
- Reset (axi4_arstn low, asynchronous):
  - State = IDLE.
  - Every output is 0: ar_ready, aw_ready, all resp_* outputs, cfg_upd_ack, miss_cnt, and all lk_* outputs.
  - Round-robin pointer favours AR.
  - Reset mid-lookup or mid-response drops the transaction; no response is produced afterwards.
- States:
  - IDLE: ar_ready/aw_ready are combinational grants.
    - Grant only if cfg_upd_req = 0.
    - Grant at most one channel per cycle.
    - Both valid: grant the pointer's channel; after any grant the pointer flips to the other channel.
    - Only one valid: grant it regardless of the pointer.
    - On handshake: register rw, addr_min, addr_max and range_err; go to LOOKUP.
    - IDLE with cfg_upd_req = 1: go to CFG.
  - LOOKUP (exactly 1 cycle):
    - lk_* outputs are driven from registers.
    - lk_* inputs are sampled at the cycle end into the response registers.
    - Go to RESP.
  - RESP:
    - resp_valid = 1; outputs hold stable until resp_ready.
    - On resp_valid & resp_ready: go to CFG if cfg_upd_req = 1, else IDLE.
  - CFG:
    - cfg_upd_ack = 1 (registered); both readies are 0.
    - Leave for IDLE the cycle after cfg_upd_req falls.
    - cfg_upd_ack deasserts in that same cycle.
- lk_* outputs are 0 in every state except LOOKUP.
- Range arithmetic:
  - bytes = (len+1) << size, computed at ADDR_WIDTH_VIRT+12 bits.
  - addr_max = addr + bytes − 1, truncated to ADDR_WIDTH_VIRT.
  - range_err = 1 if the untruncated sum exceeds 2^ADDR_WIDTH_VIRT − 1.
- Response encoding:
  - resp_miss = ~|lk_hit.
  - resp_prot = |lk_prot.
  - resp_multi = lk_multiple_hit.
  - resp_addr = lk_out_addr; forced to 0 if resp_miss, resp_prot, resp_multi or resp_range_err is set.
  - resp_master_select follows the same zero-forcing rule as resp_addr.
  - resp_range_err = registered range_err.
- Latency: request handshake at cycle N gives resp_valid at N+2. Maximum throughput is 1 request per 3 cycles.
- miss_cnt:
  - Increments by 1 on the LOOKUP cycle when the sampled resp_miss = 1.
  - Saturates at all-ones.
  - miss_cnt_clr has priority over increment when both occur in the same cycle.
- cfg_upd_req that rises during LOOKUP or RESP:
  - No new grant is issued.
  - cfg_upd_ack rises the cycle after the response handshake.

Test Plan:
- AR only: addr=0x1000, len=3, size=2, single slice hit with out_addr=0x80_0000_1000 → lk_addr_max=0x100F, lk_rw=0. Response at +2 cycles with resp_addr=0x80_0000_1000 and resp_miss=0.
- AR and AW valid in the same cycle from reset:
  - AR granted first, AW second.
  - With both held valid for 4 requests, the grant order is AR, AW, AR, AW.
- lk_hit=0 → resp_miss=1, resp_addr=0, miss_cnt increments. Preload miss_cnt=0xFFFF → it stays at 0xFFFF. Assert clear and a miss in the same cycle → miss_cnt=0.
- aw_addr=0xFFFF_FFF0, len=7, size=2 → resp_range_err=1 and resp_addr=0.
- cfg_upd_req raised during RESP with resp_ready held 0 for 3 cycles:
  - No grant occurs.
  - cfg_upd_ack rises the cycle after the handshake.
  - ar_valid is ignored until the cycle after cfg_upd_req falls.
- Reset asserted during LOOKUP → all outputs 0 immediately. After release, no stale resp_valid appears and the first grant goes to AR.
